rf_write_arbiter: RTL and testbench

Shares the single write port of the 32x32 register file between two writeback requesters: requester 0 is ALU writeback and requester 1 is load writeback. Each requester hands over an address/data pair with a valid/ready handshake into a one-entry holding register. A round-robin arbiter issues at most one write per cycle to the register file write port. The block also exports a per-register busy scoreboard so issue logic can stall reads of registers with a write still in flight.

---
 rtl/rf_write_arbiter.sv | 94 +++++++++
 tb/tb_rf_write_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU and load writeback.
// Each requester has a one-entry holding register. A per-register busy scoreboard is exported for issue stalls.
module rf_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   Req0Valid,
    output logic                   Req0Ready,
    input  logic [ADDR_W-1:0]      Req0Address,
    input  logic [DATA_W-1:0]      Req0Data,
    input  logic                   Req1Valid,
    output logic                   Req1Ready,
    input  logic [ADDR_W-1:0]      Req1Address,
    input  logic [DATA_W-1:0]      Req1Data,
    output logic [ADDR_W-1:0]      WriteAddress,
    output logic [DATA_W-1:0]      WriteData,
    output logic                   ReadWriteEn,
    output logic [2**ADDR_W-1:0]   Busy,
    output logic                   LastGrant
);

    localparam int NREG = 2**ADDR_W;

    logic [1:0]        holdValid_p0;
    logic [ADDR_W-1:0] holdAddr_p0 [2];
    logic [DATA_W-1:0] holdData_p0 [2];
    logic [1:0]        grant;
    logic [1:0]        handshake;
    logic              grantIdx;

    function automatic logic [NREG-1:0] oneHot(input logic [ADDR_W-1:0] addr, input logic en);
        logic [NREG-1:0] vec;
        vec       = '0;
        vec[addr] = en;
        return vec;
    endfunction

    // On a tie the requester that did not win last time is granted.
    assign grant[0] = holdValid_p0[0] & (~holdValid_p0[1] | LastGrant);
    assign grant[1] = holdValid_p0[1] & (~holdValid_p0[0] | ~LastGrant);
    assign grantIdx = grant[1];

    assign Req0Ready = rst_n & (~holdValid_p0[0] | grant[0]);
    assign Req1Ready = rst_n & (~holdValid_p0[1] | grant[1]);
    assign handshake = {Req1Valid & Req1Ready, Req0Valid & Req0Ready};

    // Stage p0: holding registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            holdValid_p0 <= 2'b00;
        end else begin
            holdValid_p0 <= handshake | (holdValid_p0 & ~grant);
        end
    end

    always_ff @(posedge clk) begin
        if (handshake[0]) begin
            holdAddr_p0[0] <= Req0Address;
            holdData_p0[0] <= Req0Data;
        end
        if (handshake[1]) begin
            holdAddr_p0[1] <= Req1Address;
            holdData_p0[1] <= Req1Data;
        end
    end

    // Stage p1: register-file write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            WriteAddress <= '0;
            WriteData    <= '0;
            ReadWriteEn  <= 1'b0;
            LastGrant    <= 1'b1;
        end else if (|grant) begin
            WriteAddress <= holdAddr_p0[grantIdx];
            WriteData    <= holdData_p0[grantIdx];
            ReadWriteEn  <= (holdAddr_p0[grantIdx] != '0);
            LastGrant    <= grantIdx;
        end else begin
            ReadWriteEn  <= 1'b0;
        end
    end

    // Register 0 is hard-wired zero, so it is never reported busy.
    always_comb begin
        Busy    = oneHot(holdAddr_p0[0], holdValid_p0[0])
                | oneHot(holdAddr_p0[1], holdValid_p0[1])
                | oneHot(WriteAddress, ReadWriteEn);
        Busy[0] = 1'b0;
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: a transaction-level model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        Req0Valid = 1'b0, Req1Valid = 1'b0;
    logic        Req0Ready, Req1Ready;
    logic [4:0]  Req0Address = '0, Req1Address = '0;
    logic [31:0] Req0Data = '0, Req1Data = '0;
    logic [4:0]  WriteAddress;
    logic [31:0] WriteData;
    logic        ReadWriteEn;
    logic [31:0] Busy;
    logic        LastGrant;

    int errors = 0;
    int checks = 0;
    logic chkEn = 1'b0;
    logic capture = 1'b0;
    logic [4:0] issued [$];

    rf_write_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .Req0Valid(Req0Valid), .Req0Ready(Req0Ready), .Req0Address(Req0Address), .Req0Data(Req0Data),
        .Req1Valid(Req1Valid), .Req1Ready(Req1Ready), .Req1Address(Req1Address), .Req1Data(Req1Data),
        .WriteAddress(WriteAddress), .WriteData(WriteData), .ReadWriteEn(ReadWriteEn),
        .Busy(Busy), .LastGrant(LastGrant)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: pending write per requester, last issued write, last winner.
    logic        mV [2];
    logic [4:0]  mA [2];
    logic [31:0] mD [2];
    logic [4:0]  mWA;
    logic [31:0] mWD;
    logic        mEn, mLG;

    function automatic int pickGrant();
        int n = 0;
        int who = -1;
        for (int r = 0; r < 2; r++) if (mV[r]) begin n++; who = r; end
        if (n == 2) who = mLG ? 0 : 1;
        return who;
    endfunction

    function automatic logic expReady(input int r);
        return rst_n && (!mV[r] || pickGrant() == r);
    endfunction

    function automatic logic [31:0] expBusy();
        logic [31:0] b = '0;
        for (int a = 1; a < 32; a++)
            b[a] = (mV[0] && int'(mA[0]) == a) || (mV[1] && int'(mA[1]) == a) || (mEn && int'(mWA) == a);
        return b;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mV[0] <= 1'b0; mV[1] <= 1'b0;
            mWA <= '0; mWD <= '0; mEn <= 1'b0; mLG <= 1'b1;
        end else begin
            automatic int   g   = pickGrant();
            automatic logic hs0 = Req0Valid && expReady(0);
            automatic logic hs1 = Req1Valid && expReady(1);
            if (g >= 0) begin
                mWA <= mA[g]; mWD <= mD[g]; mEn <= (mA[g] != 0); mLG <= g[0];
            end else begin
                mEn <= 1'b0;
            end
            if (hs0) begin mV[0] <= 1'b1; mA[0] <= Req0Address; mD[0] <= Req0Data; end
            else if (g == 0) mV[0] <= 1'b0;
            if (hs1) begin mV[1] <= 1'b1; mA[1] <= Req1Address; mD[1] <= Req1Data; end
            else if (g == 1) mV[1] <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chkEn) begin
            check("mdl_Req0Ready", Req0Ready, expReady(0));
            check("mdl_Req1Ready", Req1Ready, expReady(1));
            check("mdl_ReadWriteEn", ReadWriteEn, mEn);
            check("mdl_WriteAddress", WriteAddress, mWA);
            check("mdl_WriteData", WriteData, mWD);
            check("mdl_LastGrant", LastGrant, mLG);
            check("mdl_Busy", Busy, expBusy());
        end
        if (capture && ReadWriteEn) issued.push_back(WriteAddress);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0] expOrder [12];
        int i0, i1;
        logic hs0, hs1;
        expOrder = '{5'd1, 5'd10, 5'd2, 5'd11, 5'd3, 5'd12, 5'd4, 5'd13, 5'd5, 5'd14, 5'd6, 5'd15};

        // Reset values
        #2 rst_n = 1'b0;
        #1;
        check("rst_Req0Ready", Req0Ready, 0);
        check("rst_Req1Ready", Req1Ready, 0);
        check("rst_WriteAddress", WriteAddress, 0);
        check("rst_WriteData", WriteData, 0);
        check("rst_ReadWriteEn", ReadWriteEn, 0);
        check("rst_Busy", Busy, 0);
        check("rst_LastGrant", LastGrant, 1);
        @(posedge clk); tick();
        rst_n = 1'b1;
        chkEn = 1'b1;
        @(negedge clk);
        check("rel_Req0Ready", Req0Ready, 1);
        check("rel_Req1Ready", Req1Ready, 1);
        check("rel_Busy", Busy, 0);

        // Single write {8, 294}
        tick();
        Req0Valid = 1'b1; Req0Address = 5'd8; Req0Data = 32'd294;
        @(negedge clk); check("sw_ready", Req0Ready, 1);
        tick(); Req0Valid = 1'b0;
        @(negedge clk);
        check("sw_c1_busy", Busy, 32'h100);
        check("sw_c1_en", ReadWriteEn, 0);
        tick(); @(negedge clk);
        check("sw_c2_en", ReadWriteEn, 1);
        check("sw_c2_addr", WriteAddress, 8);
        check("sw_c2_data", WriteData, 294);
        check("sw_c2_busy", Busy, 32'h100);
        check("sw_c2_lg", LastGrant, 0);
        tick(); @(negedge clk);
        check("sw_c3_busy", Busy, 0);
        check("sw_c3_en", ReadWriteEn, 0);

        // Zero address from requester 1
        tick();
        Req1Valid = 1'b1; Req1Address = 5'd0; Req1Data = 32'd123;
        tick(); Req1Valid = 1'b0;
        @(negedge clk); check("z_c1_busy", Busy, 0);
        tick(); @(negedge clk);
        check("z_c2_en", ReadWriteEn, 0);
        check("z_c2_lg", LastGrant, 1);
        check("z_c2_data", WriteData, 123);
        check("z_c2_busy", Busy, 0);

        // Simultaneous handshake
        tick();
        Req0Valid = 1'b1; Req0Address = 5'd13; Req0Data = 32'd194;
        Req1Valid = 1'b1; Req1Address = 5'd3;  Req1Data = 32'd48;
        tick(); Req0Valid = 1'b0; Req1Valid = 1'b0;
        @(negedge clk); check("sim_c1_busy", Busy, 32'h2008);
        tick(); @(negedge clk);
        check("sim_c2_en", ReadWriteEn, 1);
        check("sim_c2_addr", WriteAddress, 13);
        check("sim_c2_lg", LastGrant, 0);
        check("sim_c2_busy", Busy, 32'h2008);
        tick(); @(negedge clk);
        check("sim_c3_en", ReadWriteEn, 1);
        check("sim_c3_addr", WriteAddress, 3);
        check("sim_c3_data", WriteData, 48);
        check("sim_c3_lg", LastGrant, 1);
        check("sim_c3_busy", Busy, 32'h8);
        tick(); @(negedge clk);
        check("sim_c4_busy", Busy, 0);

        // Back-to-back contention
        tick();
        capture = 1'b1;
        i0 = 0; i1 = 0;
        for (int cyc = 0; cyc < 40 && (i0 < 6 || i1 < 6); cyc++) begin
            Req0Valid = (i0 < 6); Req0Address = 5'(1 + i0);  Req0Data = 32'h100 + 32'(i0);
            Req1Valid = (i1 < 6); Req1Address = 5'(10 + i1); Req1Data = 32'h200 + 32'(i1);
            @(negedge clk);
            hs0 = Req0Valid && Req0Ready;
            hs1 = Req1Valid && Req1Ready;
            tick();
            if (hs0) i0++;
            if (hs1) i1++;
        end
        Req0Valid = 1'b0; Req1Valid = 1'b0;
        check("bb_all_accepted", ((i0 == 6) && (i1 == 6)) ? 1 : 0, 1);
        repeat (5) tick();
        capture = 1'b0;
        check("bb_count", issued.size(), 12);
        for (int k = 0; k < 12; k++)
            if (k < issued.size()) check($sformatf("bb_order%0d", k), issued[k], expOrder[k]);

        // Reset mid-flight
        tick();
        Req0Valid = 1'b1; Req0Address = 5'd10; Req0Data = 32'd123;
        tick(); Req0Valid = 1'b0;
        @(negedge clk); check("mr_c1_busy", Busy, 32'h400);
        #1 rst_n = 1'b0;
        #1;
        check("mr_busy_drop", Busy, 0);
        check("mr_en_drop", ReadWriteEn, 0);
        check("mr_ready_low", Req0Ready, 0);
        @(posedge clk); tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("mr_en_never", ReadWriteEn, 0);
            check("mr_busy_clear", Busy, 0);
        end

        chkEn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
